gf_horner_eval: RTL
===================

GF_HORNER_EVAL -- requirements
Module: gf_horner_eval

Interface
REQ-001 Parameter M, default 5: Galois field degree; symbol width in bits, legal range 3..8.
REQ-002 Parameter POLY, default 5'b00101: low M bits of the primitive polynomial, with x^M implied; the default gives x^5+x^2+1.
REQ-003 Parameter N, default 31: number of symbols per evaluation block, legal range 1..2^M-1.
REQ-004 clock  input  1: rising-edge clock for all state.
REQ-005 reset_n  input  1: reset is asynchronous and active-low; one clock, no other clock domains.
REQ-006 start  input  1: request to begin a new evaluation.
REQ-007 eval_point  input  M: GF(2^M) evaluation point, sampled when start is accepted.
REQ-008 in_valid  input  1: in_data is valid this cycle.
REQ-009 in_data  input  M: next symbol, highest-degree coefficient first.
REQ-010 in_ready  output  1: the block accepts a symbol this cycle.
REQ-011 out_valid  output  1: out_data holds the completed result.
REQ-012 out_data  output  M: polynomial value at eval_point.
REQ-013 out_ready  input  1: the consumer accepts the result.
REQ-014 busy  output  1: high in every state except IDLE.

Function
REQ-015 Symbol bit M-1 is the coefficient of x^(M-1) (MSB) in polynomial basis; bit 0 is the LSB.
REQ-016 The FSM shall have exactly three states: IDLE, ACCUM and DONE.
REQ-017 IDLE: in_ready=0, out_valid=0; on start=1 latch eval_point, clear acc to 0, clear count to 0, go to ACCUM.
REQ-018 ACCUM: in_ready=1; each cycle with in_valid=1 shall do acc <= gfmul(acc, point) XOR in_data and count <= count+1.
REQ-019 ACCUM: the symbol accepted with count==N-1 shall update acc and move to DONE in the same edge.
REQ-020 ACCUM: cycles with in_valid=0 shall hold acc and count unchanged, and there is no timeout.
REQ-021 DONE: out_valid=1, out_data=acc, in_ready=0; when out_ready=1, go to IDLE on the next edge.
REQ-022 DONE: out_data shall stay stable while out_valid=1 and out_ready=0.
REQ-023 Latency: out_valid shall rise on the cycle after the Nth accepted symbol.
REQ-024 Throughput: one symbol per cycle.
REQ-025 Minimum total cycles per block: 1 (start) + N + 1 (handshake).
REQ-026 start shall be ignored in ACCUM and DONE and shall not disturb point, acc or count.
REQ-027 in_valid outside ACCUM shall be ignored, and no symbol shall be consumed.
REQ-028 start and out_ready high together in DONE: only the return to IDLE happens; a new start is needed in IDLE.
REQ-029 gfmul shall be a full combinational polynomial-basis GF(2^M) product reduced modulo x^M+POLY, with no reliance on special operand values.
REQ-030 gfmul shall be implemented as a separate parametrised submodule, and its result shall always be exactly M bits.
REQ-031 count shall be ceil(log2(N+1)) bits wide and shall never wrap; the DONE transition happens exactly at N.
REQ-032 N=1 shall be legal: one accepted symbol gives out_data = that symbol.

Reset
REQ-033 reset_n=0 shall asynchronously force state=IDLE, acc=0, count=0, point=0, in_ready=0, out_valid=0, out_data=0 and busy=0.
REQ-034 Reset asserted in ACCUM or DONE shall abort the block; no out_valid is issued for it.
REQ-035 After reset_n rises, the first start is accepted normally.

Verification
REQ-036 Defaults, point=5'h02, symbols 5'h01 followed by 30 zeros -> out_data=5'h12 (alpha^30 = alpha^-1), out_valid on cycle 32 after start.
REQ-037 Defaults, point=5'h02, 30 zeros then 5'h01 -> out_data=5'h01.
REQ-038 Defaults, 31 symbols all 5'h00, any point -> out_data=5'h00.
REQ-039 Defaults, hold out_ready=0 for 10 cycles in DONE while pulsing start and in_valid -> out_data stable, in_ready=0, no new block starts, and state is IDLE one cycle after out_ready=1.
REQ-040 In ACCUM, drive in_valid=0 in random cycles and assert reset_n=0 after 12 symbols -> all outputs go 0 immediately, no out_valid, and a following block of REQ-036 stimulus again gives 5'h12.
REQ-041 Standalone gfmul, M=5: exhaustive 32x32 products checked against a reference model, e.g. 5'h10 x 5'h02 = 5'h05.

Source files
------------

// File: rtl/gf_horner_eval.sv
// GF(2^M) polynomial evaluator using Horner's rule.
// A block of N symbols (highest-degree coefficient first) is folded into an
// accumulator as acc = acc * point ^ symbol; the result is offered on a
// single-entry valid/ready output port.

// Combinational polynomial-basis GF(2^M) multiplier, reduced modulo x^M + POLY.
module gf_mul #(
    parameter int          M    = 5,
    parameter logic [M-1:0] POLY = 5'b00101
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);
    logic [M-1:0] prod;
    logic [M-1:0] shifted;

    // Shift-and-add: shifted walks through a*x^i (already reduced) while
    // prod accumulates the terms selected by the bits of b.
    always_comb begin
        prod    = '0;
        shifted = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) begin
                prod = prod ^ shifted;
            end
            if (shifted[M-1]) begin
                shifted = {shifted[M-2:0], 1'b0} ^ POLY;
            end else begin
                shifted = {shifted[M-2:0], 1'b0};
            end
        end
    end

    assign p = prod;
endmodule

// Handshake rules:
//   input  side: a symbol is consumed on a rising edge where in_valid and
//                in_ready are both high; in_ready is high only in ACCUM.
//   output side: the result is transferred on a rising edge where out_valid
//                and out_ready are both high; out_data is held stable while
//                out_valid is high and out_ready is low.
module gf_horner_eval #(
    parameter int           M    = 5,
    parameter logic [M-1:0] POLY = 5'b00101,
    parameter int           N    = 31
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [M-1:0] eval_point,
    input  logic         in_valid,
    input  logic [M-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [M-1:0] out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic [1:0]   state_dbg
);
    // Wide enough to hold N itself, so the counter never wraps.
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [M-1:0]  acc_q, acc_d;
    logic [M-1:0]  point_q, point_d;
    logic [CW-1:0] count_q, count_d;
    logic [M-1:0]  mul_out;

    gf_mul #(
        .M    (M),
        .POLY (POLY)
    ) u_gf_mul (
        .a (acc_q),
        .b (point_q),
        .p (mul_out)
    );

    // State and datapath registers; reset clears everything, aborting any block.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            point_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            point_q <= point_d;
            count_q <= count_d;
        end
    end

    // Next-state logic and Moore outputs; start is only honoured in IDLE.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        point_d   = point_q;
        count_d   = count_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    point_d = eval_point;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = mul_out ^ in_data;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(N - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = acc_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state_dbg = state_q;
endmodule
